axi_monitor_bw_stat: RTL
========================

Name: axi_monitor_bw_stat

Overview:
Per-port AXI traffic statistics stage in the AXI monitor. It consumes the one-cycle sample-window edge pulse produced by the monitor's window generator, and one AXI port's handshake signals sampled on ref_clk. Per window it accumulates read and write bytes, tracks outstanding transactions and checks AW/AR bursts against a programmed address range. It reports per-window totals to the monitor's report/print logic.

Parameters:
DATA_W, 64, AXI data width in bits; bytes per beat = DATA_W/8
ADDR_W, 32, AXI address width
CNT_W, 32, width of byte accumulators and error counter
OST_W, 8, width of outstanding-transaction counters

Ports:
ref_clk  in  1  monitor clock; all AXI inputs are synchronous to it
rst_n  in  1  reset
enable  in  1  statistics enable
win_pulse  in  1  sample-window edge, one cycle wide
awvalid/awready  in  1/1  AW handshake
awaddr  in  ADDR_W  write address
awlen  in  8  write burst length-1
awsize  in  3  write beat size code
wvalid/wready  in  1/1  W handshake
bvalid/bready  in  1/1  B handshake
arvalid/arready  in  1/1  AR handshake
araddr  in  ADDR_W  read address
arlen  in  8  read burst length-1
arsize  in  3  read beat size code
rvalid/rready/rlast  in  1/1/1  R handshake and last beat
addr_range_check_en  in  1  enable range check
addr_min  in  ADDR_W  inclusive lower bound
addr_max  in  ADDR_W  exclusive upper bound
stat_valid  out  1  window results valid, one-cycle pulse
wr_bytes_win  out  CNT_W  write bytes in last closed window
rd_bytes_win  out  CNT_W  read bytes in last closed window
wr_bytes_max  out  CNT_W  largest wr_bytes_win seen
rd_bytes_max  out  CNT_W  largest rd_bytes_win seen
win_cnt  out  CNT_W  number of closed windows
wr_ost  out  OST_W  outstanding writes
rd_ost  out  OST_W  outstanding reads
addr_err  out  1  range violation pulse
addr_err_rd  out  1  1 = violation was on AR
addr_err_addr  out  ADDR_W  start address of the violating burst
addr_err_cnt  out  CNT_W  total violations, saturating
ost_err  out  1  sticky flag: decrement attempted while the counter was 0

Behaviour:
- Reset is asynchronous, active-low on rst_n; clock is ref_clk. All outputs reset to 0.
- State machine:
  - IDLE: accumulators held at 0. Goes to ARMED when enable=1.
  - ARMED: waits for win_pulse so the first window is aligned. On win_pulse goes to ACCUM. No stat_valid is generated for that pulse.
  - ACCUM: on each win_pulse, closes the window. When enable=0, returns to IDLE at any point; a partial window is discarded and no stat_valid is generated.
- Accumulation in ACCUM:
  - Each wvalid&wready beat adds DATA_W/8 to the write accumulator.
  - Each rvalid&rready beat adds DATA_W/8 to the read accumulator.
  - Accumulators saturate at 2^CNT_W-1.
- Window close:
  - On win_pulse in ACCUM, accumulator values are copied to wr_bytes_win/rd_bytes_win on the next edge, and stat_valid=1 for exactly that cycle.
  - win_cnt increments on the same edge, wrapping.
  - A beat coinciding with win_pulse counts into the NEW window; the accumulator restarts at that beat's bytes, otherwise at 0.
  - Max registers update on the same edge with max(old, new).
- Outstanding counters (all states, independent of enable):
  - wr_ost: +1 on AW handshake, -1 on B handshake.
  - rd_ost: +1 on AR handshake, -1 on rlast beat.
  - Increment and decrement in the same cycle leave the counter unchanged.
  - Counters saturate at the maximum value.
  - A decrement at 0 holds the counter at 0 and sets ost_err (sticky until reset).
- Address check on each AW/AR handshake when addr_range_check_en=1:
  - end = addr + ((len+1) << size), computed in ADDR_W+9 bits with no wrap.
  - Violation if addr < addr_min OR end > addr_max.
  - addr_err pulses the cycle after the handshake, with addr_err_addr and addr_err_rd registered alongside.
  - AW and AR violations in the same cycle: addr_err_cnt increments by 2; AW details are reported (addr_err_rd=0) and AR details are dropped.
- Reset mid-operation clears all state, including max registers, sticky flags and the state machine (returns to IDLE).

Optional Feature:
AXI_MON_BW_MAX_EN
- Defined: wr_bytes_max/rd_bytes_max registers and comparators are built as described.
- Undefined: no max logic is built; wr_bytes_max and rd_bytes_max are tied to 0.

Test Plan:
1. DATA_W=64, enable=1, win_pulse every 100 cycles, 10 W beats per window -> stat_valid once per window; wr_bytes_win=80; rd_bytes_win=0; first pulse after enable produces no stat_valid.
2. W beat in the same cycle as win_pulse, preceded by 3 beats -> closed window reports 24; next window starts at 8.
3. Windows with 5, 20, 7 R beats -> rd_bytes_max = 40 → 160 → 160 (macro defined); rd_bytes_max stays 0 with macro undefined.
4. Range min=0x12EE000, max=0x133E000, check_en=1:
   - AW addr=0x133DFC0, len=7, size=3 (end=0x133E000) -> no error.
   - AR addr=0x133DFC8 same len/size -> addr_err=1, addr_err_rd=1, addr_err_addr=0x133DFC8, addr_err_cnt=1.
   - Violating AW and AR in one cycle -> addr_err_cnt increments by 2, addr_err_rd=0.
5. 3 AW handshakes, then 1 AW and 1 B in the same cycle, then 3 B handshakes -> wr_ost = 3, 3, 0. An extra B handshake -> wr_ost stays 0 and ost_err=1.
6. rst_n deasserted mid-window with wr_bytes_win=80 and wr_ost=2 -> all outputs 0 immediately; after release, the first win_pulse is treated as ARMED alignment.

Source files
------------

// File: rtl/axi_monitor_bw_stat.sv
// Per-port AXI bandwidth statistics: per-window read/write byte totals,
// outstanding transaction tracking and AW/AR address range checking.
// Optional build macro AXI_MON_BW_MAX_EN adds the per-window maximum registers;
// without it wr_bytes_max/rd_bytes_max are tied to 0.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | statistics off, accumulators held at 0
// ST_ARMED | enabled, waiting for the first win_pulse to align windows
// ST_ACCUM | accumulating; every win_pulse closes the current window

module axi_monitor_bw_stat #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32,
  parameter int OST_W  = 8
) (
  input  logic              ref_clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              win_pulse,
  input  logic              awvalid,
  input  logic              awready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic              wvalid,
  input  logic              wready,
  input  logic              bvalid,
  input  logic              bready,
  input  logic              arvalid,
  input  logic              arready,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic              rvalid,
  input  logic              rready,
  input  logic              rlast,
  input  logic              addr_range_check_en,
  input  logic [ADDR_W-1:0] addr_min,
  input  logic [ADDR_W-1:0] addr_max,
  output logic              stat_valid,
  output logic [CNT_W-1:0]  wr_bytes_win,
  output logic [CNT_W-1:0]  rd_bytes_win,
  output logic [CNT_W-1:0]  wr_bytes_max,
  output logic [CNT_W-1:0]  rd_bytes_max,
  output logic [CNT_W-1:0]  win_cnt,
  output logic [OST_W-1:0]  wr_ost,
  output logic [OST_W-1:0]  rd_ost,
  output logic              addr_err,
  output logic              addr_err_rd,
  output logic [ADDR_W-1:0] addr_err_addr,
  output logic [CNT_W-1:0]  addr_err_cnt,
  output logic              ost_err
);

  localparam logic [CNT_W-1:0] BEAT_BYTES = CNT_W'(DATA_W / 8);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [OST_W-1:0] OST_MAX    = '1;
  // Burst end address needs 9 extra bits: (len+1) << size is at most 2^15.
  localparam int               END_W      = ADDR_W + 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_ACCUM = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic w_beat, r_beat, aw_hs, ar_hs, b_hs, rlast_hs;
  logic win_open, win_close, accum_on;
  logic aw_viol, ar_viol;
  logic [CNT_W-1:0] wr_acc, rd_acc;

  assign w_beat   = wvalid & wready;
  assign r_beat   = rvalid & rready;
  assign aw_hs    = awvalid & awready;
  assign ar_hs    = arvalid & arready;
  assign b_hs     = bvalid & bready;
  assign rlast_hs = rvalid & rready & rlast;

  // The aligning pulse opens the first window without reporting anything.
  assign accum_on  = (state == ST_ACCUM) & enable;
  assign win_open  = (state == ST_ARMED) & enable & win_pulse;
  assign win_close = accum_on & win_pulse;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
  endfunction

  function automatic logic range_bad(input logic [ADDR_W-1:0] addr,
                                     input logic [7:0]        len,
                                     input logic [2:0]        size,
                                     input logic [ADDR_W-1:0] lo,
                                     input logic [ADDR_W-1:0] hi);
    logic [END_W-1:0] span;
    logic [END_W-1:0] last;
    span = END_W'({1'b0, len} + 9'd1) << size;
    last = END_W'(addr) + span;
    return (addr < lo) || (last > END_W'(hi));
  endfunction

  assign aw_viol = addr_range_check_en & aw_hs &
                   range_bad(awaddr, awlen, awsize, addr_min, addr_max);
  assign ar_viol = addr_range_check_en & ar_hs &
                   range_bad(araddr, arlen, arsize, addr_min, addr_max);

  // State register.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; dropping enable abandons any partial window.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (enable) state_nxt = ST_ARMED;
      ST_ARMED: if (!enable) state_nxt = ST_IDLE;
                else if (win_pulse) state_nxt = ST_ACCUM;
      ST_ACCUM: if (!enable) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Byte accumulators; a beat on the window edge starts the new window.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_acc <= '0;
      rd_acc <= '0;
    end else if (win_open || win_close) begin
      wr_acc <= w_beat ? BEAT_BYTES : '0;
      rd_acc <= r_beat ? BEAT_BYTES : '0;
    end else if (accum_on) begin
      if (w_beat) wr_acc <= sat_add(wr_acc, BEAT_BYTES);
      if (r_beat) rd_acc <= sat_add(rd_acc, BEAT_BYTES);
    end else begin
      wr_acc <= '0;
      rd_acc <= '0;
    end
  end

  // Window close: publish totals, pulse stat_valid, count windows.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_valid   <= 1'b0;
      wr_bytes_win <= '0;
      rd_bytes_win <= '0;
      win_cnt      <= '0;
    end else begin
      stat_valid <= win_close;
      if (win_close) begin
        wr_bytes_win <= wr_acc;
        rd_bytes_win <= rd_acc;
        win_cnt      <= win_cnt + CNT_W'(1);
      end
    end
  end

`ifdef AXI_MON_BW_MAX_EN
  logic [CNT_W-1:0] wr_max_q, rd_max_q;

  // Running maximum of closed-window totals.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_max_q <= '0;
      rd_max_q <= '0;
    end else if (win_close) begin
      if (wr_acc > wr_max_q) wr_max_q <= wr_acc;
      if (rd_acc > rd_max_q) rd_max_q <= rd_acc;
    end
  end

  assign wr_bytes_max = wr_max_q;
  assign rd_bytes_max = rd_max_q;
`else
  assign wr_bytes_max = '0;
  assign rd_bytes_max = '0;
`endif

  // Outstanding counters run regardless of enable; simultaneous +1/-1 cancel.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ost <= '0;
      rd_ost <= '0;
    end else begin
      if (aw_hs && !b_hs) begin
        if (wr_ost != OST_MAX) wr_ost <= wr_ost + OST_W'(1);
      end else if (b_hs && !aw_hs) begin
        if (wr_ost != '0) wr_ost <= wr_ost - OST_W'(1);
      end
      if (ar_hs && !rlast_hs) begin
        if (rd_ost != OST_MAX) rd_ost <= rd_ost + OST_W'(1);
      end else if (rlast_hs && !ar_hs) begin
        if (rd_ost != '0) rd_ost <= rd_ost - OST_W'(1);
      end
    end
  end

  // Sticky underflow flag for either outstanding counter.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      ost_err <= 1'b0;
    end else if ((b_hs && !aw_hs && wr_ost == '0) ||
                 (rlast_hs && !ar_hs && rd_ost == '0)) begin
      ost_err <= 1'b1;
    end
  end

  // Range violation report; AW wins the detail registers when both hit.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_err      <= 1'b0;
      addr_err_rd   <= 1'b0;
      addr_err_addr <= '0;
      addr_err_cnt  <= '0;
    end else begin
      addr_err     <= aw_viol | ar_viol;
      addr_err_cnt <= sat_add(addr_err_cnt, CNT_W'(aw_viol) + CNT_W'(ar_viol));
      if (aw_viol) begin
        addr_err_rd   <= 1'b0;
        addr_err_addr <= awaddr;
      end else if (ar_viol) begin
        addr_err_rd   <= 1'b1;
        addr_err_addr <= araddr;
      end
    end
  end

endmodule
